spi_ram_ctrl: RTL and testbench

//  Command-decoding single-port RAM that sits directly downstream of the SPI slave.

---
 rtl/spi_ram_pkg.sv | 16 +
 rtl/sp_ram.sv | 28 ++
 rtl/spi_ram_ctrl.sv | 141 ++++++++++++++
 tb/tb_spi_ram_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared command codes and read-FSM encodings for the SPI command RAM.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ADDR  = 2'd1,
    RD_FETCH = 2'd2,
    RD_SEND  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/sp_ram.sv
// DEPTH x 8 storage array: one synchronous write and one registered read per
// cycle. A read and a write to the same entry on the same edge returns the
// old contents. No reset: contents are undefined after power-up.
module sp_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // Non-blocking read and write on the same edge give read-before-write.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder + RAM behind an SPI slave: address/data write commands,
// a read FSM that fetches one byte and holds tx_valid for TX_HOLD cycles.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int TX_HOLD   = 8,
  parameter int AUTO_INC  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       cmd_err
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(TX_HOLD + 1);

  rd_state_e            st_q, st_d;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic                 wr_vld_q, wr_vld_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 err_q, err_d;
  logic                 wr_en;
  logic [7:0]           ram_q;

  logic [1:0] cmd;
  logic [7:0] pl;
  logic       pl_ok;

  assign cmd   = rx_data[9:8];
  assign pl    = rx_data[7:0];
  assign pl_ok = ({1'b0, pl} < 9'(MEM_DEPTH));

  function automatic logic [ADDR_SIZE-1:0] wrap_inc(input logic [ADDR_SIZE-1:0] a);
    return (a == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  // Command decode, read FSM next state, hold counter and output next values.
  always_comb begin
    st_d       = st_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_vld_d   = wr_vld_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = (st_q == RD_SEND);
    err_d      = 1'b0;
    wr_en      = 1'b0;

    if (rx_valid) begin
      case (cmd)
        CMD_WR_ADDR: begin
          if (pl_ok) begin
            wr_addr_d = ADDR_SIZE'(pl);
            wr_vld_d  = 1'b1;
          end else err_d = 1'b1;
        end
        CMD_WR_DATA: begin
          if (wr_vld_q) begin
            wr_en = 1'b1;
            if (AUTO_INC != 0) wr_addr_d = wrap_inc(wr_addr_q);
          end else err_d = 1'b1;
        end
        CMD_RD_ADDR: begin
          if (pl_ok && (st_q == RD_IDLE || st_q == RD_ADDR)) begin
            rd_addr_d = ADDR_SIZE'(pl);
            st_d      = RD_ADDR;
          end else err_d = 1'b1;
        end
        CMD_RD_DATA: begin
          if (st_q == RD_ADDR) st_d = RD_FETCH;
          else err_d = 1'b1;
        end
      endcase
    end

    // RD commands are rejected in FETCH/SEND, so these never collide with decode.
    case (st_q)
      RD_FETCH: begin
        cnt_d = CW'(TX_HOLD);
        st_d  = RD_SEND;
      end
      RD_SEND: begin
        if (cnt_q == CW'(TX_HOLD)) tx_data_d = ram_q;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          if (AUTO_INC != 0) begin
            st_d      = RD_ADDR;
            rd_addr_d = wrap_inc(rd_addr_q);
          end else st_d = RD_IDLE;
        end
      end
      default: ;
    endcase
  end

  // State and output registers; reset aborts any fetch or hold immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= RD_IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_vld_q   <= 1'b0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      st_q       <= st_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_vld_q   <= wr_vld_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
    end
  end

  sp_ram #(.DEPTH(MEM_DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_addr_q[AW-1:0]),
    .wdata_i (pl),
    .re_i    (st_q == RD_FETCH),
    .raddr_i (rd_addr_q[AW-1:0]),
    .rdata_o (ram_q)
  );

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign cmd_err  = err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: three instances cover the default config,
// a 16-deep auto-increment config and a 256-deep auto-increment config.
module tb_spi_ram_ctrl;
  import spi_ram_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] rxd [3];
  logic       rxv [3];
  logic [7:0] txd [3];
  logic       txv [3];
  logic       err [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc;

  // per-instance monitor: start cycle/data and length of last tx_valid run
  int       st_c [3];
  int       ln   [3];
  logic [7:0] sd [3];
  int       ecnt [3];
  int       vcnt [3];
  logic     prv  [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .TX_HOLD(8), .AUTO_INC(0)) dut0 (
    .clk(clk), .rst(rst), .rx_data(rxd[0]), .rx_valid(rxv[0]),
    .tx_data(txd[0]), .tx_valid(txv[0]), .cmd_err(err[0]));
  spi_ram_ctrl #(.MEM_DEPTH(16), .ADDR_SIZE(8), .TX_HOLD(3), .AUTO_INC(1)) dut1 (
    .clk(clk), .rst(rst), .rx_data(rxd[1]), .rx_valid(rxv[1]),
    .tx_data(txd[1]), .tx_valid(txv[1]), .cmd_err(err[1]));
  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .TX_HOLD(8), .AUTO_INC(1)) dut2 (
    .clk(clk), .rst(rst), .rx_data(rxd[2]), .rx_valid(rxv[2]),
    .tx_data(txd[2]), .tx_valid(txv[2]), .cmd_err(err[2]));

  // Track tx_valid runs, cmd_err pulses and total valid cycles per instance.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (txv[i] && !prv[i]) begin
        st_c[i] <= cyc;
        sd[i]   <= txd[i];
      end
      if (!txv[i] && prv[i]) ln[i] <= cyc - st_c[i];
      if (err[i] === 1'b1) ecnt[i] <= ecnt[i] + 1;
      if (txv[i] === 1'b1) vcnt[i] <= vcnt[i] + 1;
      prv[i] <= txv[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input int i, input logic [1:0] c, input logic [7:0] p);
    @(negedge clk);
    rxd[i] = {c, p};
    rxv[i] = 1'b1;
    @(posedge clk);
    #1;
    last_acc = cyc;
    rxv[i] = 1'b0;
  endtask

  task automatic send_chk(input int i, input logic [1:0] c, input logic [7:0] p,
                          input logic exp_err, input string tag);
    send(i, c, p);
    @(negedge clk);
    chk(tag, err[i], exp_err);
  endtask

  // Wait out a read started at edge 'acc' and check its timing and data.
  task automatic rd_chk(input int i, input int acc, input logic [7:0] d,
                        input int hold, input string tag);
    repeat (hold + 5) @(negedge clk);
    #1;
    chk({tag, "_start"}, st_c[i], acc + 2);
    chk({tag, "_len"},   ln[i],   hold);
    chk({tag, "_data"},  sd[i],   d);
    chk({tag, "_keep"},  txd[i],  d);
    chk({tag, "_vlow"},  txv[i],  1'b0);
  endtask

  int a, vs, es;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rxd[i] = '0; rxv[i] = 1'b0;
      ecnt[i] = 0; vcnt[i] = 0; ln[i] = 0; st_c[i] = 0; sd[i] = '0; prv[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_txd", txd[i], 8'h00);
      chk("rst_txv", txv[i], 1'b0);
      chk("rst_err", err[i], 1'b0);
    end
    rst = 1'b0;

    // basic write then read, default config
    send_chk(0, CMD_WR_ADDR, 8'h10, 1'b0, "t2_wa");
    send_chk(0, CMD_WR_DATA, 8'hA5, 1'b0, "t2_wd");
    send_chk(0, CMD_RD_ADDR, 8'h10, 1'b0, "t2_ra");
    send(0, CMD_RD_DATA, 8'h00);
    rd_chk(0, last_acc, 8'hA5, 8, "t2");

    // read commands during SEND are rejected and do not disturb the transfer
    send_chk(0, CMD_WR_ADDR, 8'h20, 1'b0, "t5_wa");
    send_chk(0, CMD_WR_DATA, 8'h5A, 1'b0, "t5_wd");
    send_chk(0, CMD_RD_ADDR, 8'h10, 1'b0, "t5_ra");
    send(0, CMD_RD_DATA, 8'h00);
    a = last_acc;
    repeat (3) @(negedge clk);
    send_chk(0, CMD_RD_DATA, 8'h00, 1'b1, "t5_rd_err");
    send_chk(0, CMD_RD_ADDR, 8'h20, 1'b1, "t5_ra_err");
    rd_chk(0, a, 8'hA5, 8, "t5");

    // reset mid-SEND aborts the hold; RD_DATA afterwards is rejected
    send_chk(0, CMD_WR_ADDR, 8'h00, 1'b0, "t1_wa");
    send_chk(0, CMD_WR_DATA, 8'h3C, 1'b0, "t1_wd");
    send_chk(0, CMD_RD_ADDR, 8'h00, 1'b0, "t1_ra");
    send(0, CMD_RD_DATA, 8'h00);
    repeat (4) @(negedge clk);
    chk("t1_mid_v", txv[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("t1_rst_v", txv[0], 1'b0);
    chk("t1_rst_d", txd[0], 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    vs = vcnt[0];
    es = ecnt[0];
    send_chk(0, CMD_RD_DATA, 8'h00, 1'b1, "t1_rd_err");
    repeat (12) @(negedge clk);
    #1;
    chk("t1_novalid", vcnt[0], vs);
    chk("t1_errpulse", ecnt[0], es + 1);

    // WR_DATA without an address is rejected and never lands in RAM
    send_chk(0, CMD_WR_DATA, 8'h77, 1'b1, "t3_wd_err");
    send_chk(0, CMD_WR_ADDR, 8'h00, 1'b0, "t3_wa");
    send_chk(0, CMD_WR_DATA, 8'h42, 1'b0, "t3_wd");
    send_chk(0, CMD_RD_ADDR, 8'h00, 1'b0, "t3_ra");
    send(0, CMD_RD_DATA, 8'h00);
    rd_chk(0, last_acc, 8'h42, 8, "t3");

    // 16-deep, auto-increment: address range and write wrap
    send_chk(1, CMD_WR_ADDR, 8'h20, 1'b1, "t4_wa_oob");
    send_chk(1, CMD_WR_ADDR, 8'h0F, 1'b0, "t4_wa_max");
    send_chk(1, CMD_WR_DATA, 8'hB1, 1'b0, "t4_wd0");
    send_chk(1, CMD_WR_DATA, 8'hB2, 1'b0, "t4_wd1");
    send_chk(1, CMD_RD_ADDR, 8'h10, 1'b1, "t4_ra_oob");
    send_chk(1, CMD_RD_ADDR, 8'h0F, 1'b0, "t4_ra");
    send(1, CMD_RD_DATA, 8'h00);
    rd_chk(1, last_acc, 8'hB1, 3, "t4a");
    send(1, CMD_RD_DATA, 8'h00);
    rd_chk(1, last_acc, 8'hB2, 3, "t4b");

    // 256-deep, auto-increment: read wrap and read-before-write in fetch
    send_chk(2, CMD_WR_ADDR, 8'hFE, 1'b0, "t6_wa");
    send_chk(2, CMD_WR_DATA, 8'h11, 1'b0, "t6_wd0");
    send_chk(2, CMD_WR_DATA, 8'h22, 1'b0, "t6_wd1");
    send_chk(2, CMD_WR_DATA, 8'h33, 1'b0, "t6_wd2");
    send_chk(2, CMD_RD_ADDR, 8'hFE, 1'b0, "t6_ra");
    send(2, CMD_RD_DATA, 8'h00);
    rd_chk(2, last_acc, 8'h11, 8, "t6a");
    send(2, CMD_RD_DATA, 8'h00);
    rd_chk(2, last_acc, 8'h22, 8, "t6b");
    send(2, CMD_RD_DATA, 8'h00);
    rd_chk(2, last_acc, 8'h33, 8, "t6c");
    // rd_addr is now 0x01
    send_chk(2, CMD_WR_ADDR, 8'h01, 1'b0, "t6_wa1");
    send_chk(2, CMD_WR_DATA, 8'h44, 1'b0, "t6_wd44");
    send_chk(2, CMD_WR_ADDR, 8'h01, 1'b0, "t6_wa1b");
    send(2, CMD_RD_DATA, 8'h00);
    a = last_acc;
    send(2, CMD_WR_DATA, 8'h55);
    rd_chk(2, a, 8'h44, 8, "t6_rbw");
    send_chk(2, CMD_RD_ADDR, 8'h01, 1'b0, "t6_ra1");
    send(2, CMD_RD_DATA, 8'h00);
    rd_chk(2, last_acc, 8'h55, 8, "t6_new");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
